// File: rtl/mul_defs_pkg.sv
// Shared definitions for the memory-mapped multiplier: register map,
// CTRL/STATUS bit positions and core state encodings.
package mul_defs;

  localparam logic [1:0] ADDR_OPA    = 2'd0;
  localparam logic [1:0] ADDR_OPB    = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_SIGNED   = 1;
  localparam int CTRL_HI_SEL   = 2;
  localparam int CTRL_CLR_DONE = 3;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_SIGNED = 2;
  localparam int STAT_HI_SEL = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_core.sv
// Iterative shift-add multiplier: magnitude load, BITS_PER_CYCLE-wide
// accumulate per RUN cycle, then a single FIX cycle applying the sign.
module mul_core
  import mul_defs::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               busy,
  output logic               fix_valid,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;

  mul_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              neg_q, neg_d;

  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [PW-1:0]     terms [BITS_PER_CYCLE];
  logic [PW-1:0]     step_sum;

  // Negating the most negative value yields 2^(WIDTH-1), which is exactly
  // the magnitude we want when the result is treated as unsigned.
  assign mag_a = (signed_mode && opa[WIDTH-1]) ? -opa : opa;
  assign mag_b = (signed_mode && opb[WIDTH-1]) ? -opb : opb;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_terms
    assign terms[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
  end

  always_comb begin
    step_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      step_sum = step_sum + terms[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          cnt_d    = CW'(N);
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = signed_mode && (opa[WIDTH-1] ^ opb[WIDTH-1]);
        end
      end
      ST_RUN: begin
        acc_d    = acc_q + step_sum;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign fix_valid = (state_q == ST_FIX);
  assign product   = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/mul_periph.sv
// Bus-facing wrapper: operand/control/result registers, write decode and a
// combinational read mux around the iterative multiplier core.
module mul_periph
  import mul_defs::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               signed_q, signed_d;
  logic               hi_sel_q, hi_sel_d;
  logic               done_q, done_d;

  logic               wr, wr_ctrl, start;
  logic               core_busy, core_fix;
  logic [2*WIDTH-1:0] core_product;
  logic [WIDTH-1:0]   status;

  mul_core #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (wdata[CTRL_SIGNED]),
    .opa         (opa_q),
    .opb         (opb_q),
    .busy        (core_busy),
    .fix_valid   (core_fix),
    .product     (core_product)
  );

  always_comb begin
    wr       = ce && we;
    wr_ctrl  = wr && (addr == ADDR_CTRL);
    start    = wr_ctrl && wdata[CTRL_START] && !core_busy;

    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    signed_d = signed_q;
    hi_sel_d = hi_sel_q;
    done_d   = done_q;

    if (wr && (addr == ADDR_OPA) && !core_busy) opa_d = wdata;
    if (wr && (addr == ADDR_OPB) && !core_busy) opb_d = wdata;
    if (wr_ctrl) hi_sel_d = wdata[CTRL_HI_SEL];
    if (start)   signed_d = wdata[CTRL_SIGNED];

    // Later assignments take priority: a start always leaves done cleared.
    if (wr_ctrl && wdata[CTRL_CLR_DONE]) done_d = 1'b0;
    if (core_fix) begin
      done_d   = 1'b1;
      result_d = core_product;
    end
    if (start) done_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      signed_q <= 1'b0;
      hi_sel_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      signed_q <= signed_d;
      hi_sel_q <= hi_sel_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    status              = '0;
    status[STAT_BUSY]   = core_busy;
    status[STAT_DONE]   = done_q;
    status[STAT_SIGNED] = signed_q;
    status[STAT_HI_SEL] = hi_sel_q;

    rdata = '0;
    if (ce) begin
      case (addr)
        ADDR_OPA:    rdata = opa_q;
        ADDR_OPB:    rdata = opb_q;
        ADDR_CTRL:   rdata = status;
        ADDR_RESULT: rdata = hi_sel_q ? result_q[2*WIDTH-1:WIDTH] : result_q[WIDTH-1:0];
        default:     rdata = '0;
      endcase
    end
  end

  assign busy = core_busy;
  assign done = done_q;

endmodule

// File: tb/tb_mul_periph.sv
// Scoreboard bench for mul_periph: expected products are queued at start
// and compared once the run completes.
module tb_mul_periph;
  import mul_defs::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, ce, we;
  logic [1:0]   addr;
  logic [W-1:0] wdata, rdata;
  logic         busy, done;

  always #5 clk = ~clk;

  mul_periph #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .done  (done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           n_chk = 0;
  int           n_pass = 0;
  int           start_cyc = 0;
  logic [63:0]  sb_q[$];
  logic [W-1:0] rd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [W-1:0] d);
    ce = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [W-1:0] d);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    ce = 1'b0;
  endtask

  task automatic start_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ctrl);
    logic [63:0] ea, eb;
    bus_wr(ADDR_OPA, a);
    bus_wr(ADDR_OPB, b);
    ea = ctrl[CTRL_SIGNED] ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = ctrl[CTRL_SIGNED] ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    sb_q.push_back(ea * eb);
    bus_wr(ADDR_CTRL, ctrl);
    start_cyc = cyc;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    check_eq({tag, "_done_clr"}, 64'(done), 64'd0);
    $display("start %s a=0x%08h b=0x%08h ctrl=0x%0h", tag, a, b, ctrl);
  endtask

  task automatic finish_mul(input string tag);
    int n;
    logic [63:0]  exp;
    logic [W-1:0] lo, hi;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_lat"}, 64'(cyc - start_cyc), 64'd33);
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'd0;
    bus_wr(ADDR_CTRL, 32'h0);
    bus_rd(ADDR_RESULT, lo);
    bus_wr(ADDR_CTRL, 32'h4);
    bus_rd(ADDR_RESULT, hi);
    bus_wr(ADDR_CTRL, 32'h0);
    check_eq({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    check_eq({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
    $display("done  %s result=0x%08h_%08h expected=0x%016h", tag, hi, lo, exp);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    bus_rd(ADDR_OPA, rd);    check_eq("rst_opa", 64'(rd), 64'd0);
    bus_rd(ADDR_OPB, rd);    check_eq("rst_opb", 64'(rd), 64'd0);
    bus_rd(ADDR_RESULT, rd); check_eq("rst_result", 64'(rd), 64'd0);
    bus_rd(ADDR_CTRL, rd);   check_eq("rst_status", 64'(rd), 64'd0);

    start_mul("u7x6", 32'd7, 32'd6, 32'h1);
    finish_mul("u7x6");
    bus_rd(ADDR_CTRL, rd);   check_eq("status_u", 64'(rd), 64'h2);

    start_mul("s_m3x5", 32'hFFFF_FFFD, 32'd5, 32'h3);
    finish_mul("s_m3x5");
    bus_rd(ADDR_CTRL, rd);   check_eq("status_s", 64'(rd), 64'h6);

    // start together with clr_done: done must end cleared (checked in start_mul)
    start_mul("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h9);
    finish_mul("u_ffxff");

    start_mul("s_minxmin", 32'h8000_0000, 32'h8000_0000, 32'h3);
    finish_mul("s_minxmin");

    bus_wr(ADDR_CTRL, 32'h4);
    bus_rd(ADDR_CTRL, rd);   check_eq("status_hisel", 64'(rd), 64'hE);
    bus_wr(ADDR_CTRL, 32'h8);
    check_eq("clr_done", 64'(done), 64'd0);
    bus_rd(ADDR_CTRL, rd);   check_eq("status_clr", 64'(rd), 64'h4);

    ce = 1'b0; addr = ADDR_OPA; #1;
    check_eq("ce_low_rdata", 64'(rdata), 64'd0);

    // writes while busy must not disturb the run or restart it
    start_mul("busy_ign", 32'd11, 32'd13, 32'h1);
    repeat (9) @(posedge clk);
    #1;
    bus_wr(ADDR_OPA, 32'd9);
    bus_wr(ADDR_CTRL, 32'h1);
    finish_mul("busy_ign");
    bus_rd(ADDR_OPA, rd);    check_eq("busy_opa_kept", 64'(rd), 64'd11);

    // reset mid-run aborts without completion
    start_mul("abort", 32'd5, 32'd7, 32'h1);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    $display("reset asserted mid-run at cycle %0d", cyc - start_cyc);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    bus_rd(ADDR_OPA, rd);    check_eq("abort_opa", 64'(rd), 64'd0);
    bus_rd(ADDR_OPB, rd);    check_eq("abort_opb", 64'(rd), 64'd0);
    bus_rd(ADDR_RESULT, rd); check_eq("abort_result", 64'(rd), 64'd0);
    bus_rd(ADDR_CTRL, rd);   check_eq("abort_status", 64'(rd), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("abort_no_done", 64'(done), 64'd0);

    start_mul("u2x3", 32'd2, 32'd3, 32'h1);
    finish_mul("u2x3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_periph.md
# mul_periph

Memory-mapped iterative multiplier that responds on the CPU data bus alongside dmem and the accumulator, selected by the arbiter through its `ce` enable. The CPU loads two 32-bit operands, writes a start command, and reads a 64-bit product after a fixed multi-cycle run. Progress is reported through a status register. A `busy` output is available to drive the CPU `stall` input.

## Interface
- `WIDTH`, default 32: operand and bus data width. Must equal the CPU data width.
- `BITS_PER_CYCLE`, default 1: multiplier bits consumed per RUN cycle. Legal values are 1, 2 and 4, and the value must divide `WIDTH`.
- `clk` in 1: clock. Instantiated on `~clk` like the other bus responders.
- `reset` in 1: synchronous, active-high reset.
- `ce` in 1: chip enable from the arbiter. Writes are ignored when `ce` is low.
- `we` in 1: write strobe. Driven as `we != 0` from the CPU byte enables.
- `addr` in 2: word address, `daddr[3:2]`.
- `wdata` in WIDTH: write data.
- `rdata` out WIDTH: read data.
- `busy` out 1: high while a multiply is in progress.
- `done` out 1: sticky completion flag.

## Operation
- Register map:
  - 0: OPA (RW).
  - 1: OPB (RW).
  - 2: CTRL/STATUS.
  - 3: RESULT.
- CTRL write bits:
  - b0 `start`.
  - b1 `signed`: operands are two's complement.
  - b2 `hi_sel`: RESULT reads return the upper half of the product.
  - b3 `clr_done`: write 1 to clear `done`.
- STATUS read: b0 busy, b1 done, b2 signed, b3 hi_sel. All other bits read 0.
- State machine with states IDLE, RUN and FIX:
  - IDLE→RUN on a CTRL write with `start`=1. On that transition: latch `signed`; load magnitudes of OPA and OPB (or the raw values when unsigned); clear the partial product; set the iteration counter to `WIDTH/BITS_PER_CYCLE`; clear `done`.
  - RUN, each cycle: add the multiplicand times the low `BITS_PER_CYCLE` multiplier bits into a 2·WIDTH partial product; shift; decrement the counter. Move to FIX when the counter reaches 0.
  - FIX: negate the 2·WIDTH product if signed mode is on and the operand signs differ. Write the RESULT register atomically, set `done`, and return to IDLE.
- Arithmetic rules:
  - All arithmetic is modulo 2^(2·WIDTH).
  - The magnitude of 0x80000000 is 2^31 and is treated as an unsigned value, so no overflow occurs.
- `hi_sel` and `clr_done` take effect on any CTRL write, including writes made while busy.
- While busy, these are ignored: OPA/OPB writes and `start`. `start` is not queued.
- The RESULT register holds the previous product until FIX completes. Intermediate state is never visible.
- `start` and `clr_done` written in the same cycle: `start` wins and `done` ends cleared.
- `rdata` is combinational from `addr` and the registers when `ce`=1, and is 0 when `ce`=0.

## Timing
- Reset values: OPA, OPB and RESULT are 0; `busy` and `done` are 0; `signed` and `hi_sel` are 0; state is IDLE.
- Reset asserted mid-run aborts the operation immediately at that edge, with no completion.
- With the start write at edge k:
  - `busy` is 1 after edge k.
  - The last RUN iteration occurs at edge k+N, where N = `WIDTH/BITS_PER_CYCLE`.
  - FIX occurs at edge k+N+1. After that edge, `busy`=0, `done`=1, and RESULT is valid.
- Default latency is 33 cycles from start to a valid result.
- A new start is accepted at edge k+N+2 at the earliest.
- Reads have zero-cycle latency, the same as the accumulator.

## Structure
- Shared package/include `mul_defs` holds:
  - register address constants;
  - CTRL/STATUS bit positions;
  - state encodings for IDLE, RUN and FIX.
- Sub-module `mul_core` contains the operand magnitude logic, the shift-add engine, the counter, the FSM and sign fix. It has a start/signed/operand input side and a busy/done/product output side.
- `mul_periph` itself holds the bus decode, the OPA/OPB/CTRL/RESULT registers and the read mux.

## Test plan
- Unsigned 7 × 6: set OPA=7, OPB=6, write CTRL=0x1, and wait 33 cycles. Expect `done`=1 and RESULT=42. With `hi_sel`=1, RESULT=0.
- Signed −3 × 5: set OPA=0xFFFFFFFD, OPB=5, write CTRL=0x3. Expect lo=0xFFFFFFF1 and hi=0xFFFFFFFF.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF. Expect hi=0xFFFFFFFE, lo=0x00000001.
- Signed 0x80000000 × 0x80000000. Expect hi=0x40000000, lo=0.
- At cycle 10 of a run, write OPA=9 and CTRL=0x1. Expect the original product, OPA unchanged, and `done` at cycle 33 (not 43).
- Assert `reset` at cycle 20 of a run. Expect `busy`=0, `done`=0 and all registers 0 on the next cycle. A subsequent 2 × 3 run must return 6.
